// File: rtl/rv32i_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// immediate formats and ALU operation codes.
package rv32i_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ITY = 2'b00;
  localparam logic [1:0] STY = 2'b01;
  localparam logic [1:0] BTY = 2'b10;
  localparam logic [1:0] JTY = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Only add/sub, slt, or and and are implemented for register and immediate ALU ops.
  function automatic logic funct3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: turns the FSM's coarse ALU request plus instruction fields
// into the ALU operation select.
module aludec
  import rv32i_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op5=1) with funct7b5 set subtracts; addi never does.
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I controller: main FSM, immediate-format decode, sticky
// illegal-instruction flag and retired-instruction counter.
module mc_controller
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pcwrite,
  output logic        adrsrc,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regwrite,
  output logic [1:0]  resultsrc,
  output logic [1:0]  alusrca,
  output logic [1:0]  alusrcb,
  output logic [2:0]  alucontrol,
  output logic [1:0]  immsrc,
  output logic        illegal,
  output logic [31:0] instret
);

  state_t     state, next_state;
  logic [1:0] aluop;
  logic       pcw, memw, irw, regw;
  logic       retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pcw        = 1'b0;
    memw       = 1'b0;
    irw        = 1'b0;
    regw       = 1'b0;
    adrsrc     = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    aluop      = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        if (mem_ready) begin
          irw        = 1'b1;
          pcw        = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = funct3_ok(funct3) ? S_EXECR : S_TRAP;
          OP_ITYPE:     next_state = funct3_ok(funct3) ? S_EXECI : S_TRAP;
          OP_BEQ:       next_state = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        next_state = (op == OP_SW) ? S_MEMWR : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc  = 2'b01;
        regw       = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        alusrca    = 2'b10;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        regw       = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        alusrca    = 2'b10;
        aluop      = ALUOP_SUB;
        pcw        = zero;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        pcw        = 1'b1;
        next_state = S_ALUWB;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

  // Write enables are gated by reset so a held MEM_READY cannot leak a write during reset.
  assign pcwrite  = pcw  & rst_n;
  assign memwrite = memw & rst_n;
  assign irwrite  = irw  & rst_n;
  assign regwrite = regw & rst_n;

  always_comb begin
    case (op)
      OP_LW, OP_ITYPE: immsrc = ITY;
      OP_SW:           immsrc = STY;
      OP_BEQ:          immsrc = BTY;
      OP_JAL:          immsrc = JTY;
      default:         immsrc = ITY;
    endcase
  end

  aludec u_aludec (
    .aluop      (aluop),
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  ((state == S_MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
      instret <= 32'd0;
    end else begin
      if (next_state == S_TRAP) illegal <= 1'b1;
      if (retire)               instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: decode table, directed corner cases
// and a randomized instruction stream against a phase-list reference model.
module tb_mc_controller;

  logic        clk;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0]  resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0]  alucontrol;
  logic [31:0] instret;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_instret;
  int          seq[$];

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                 P_MEMWR = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BEQ = 9,
                 P_JAL = 10, P_TRAP = 11;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       trap;
  } vector_t;

  vector_t vecs[15];

  mc_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .immsrc     (immsrc),
    .illegal    (illegal),
    .instret    (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == LW || o == IT) return 2'b00;
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3);
    return f3 inside {3'b000, 3'b010, 3'b110, 3'b111};
  endfunction

  // Expected outputs for one cycle spent in a given phase of an instruction.
  function automatic logic [16:0] model_outputs(input int ph, input logic rdy, input logic z,
                                                input logic [6:0] o, input logic [2:0] f3,
                                                input logic f7);
    logic pcw, adr, memw, irw, regw, ill;
    logic [1:0] res, a, b;
    logic [2:0] alu;
    pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0; ill = 0;
    res = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
    case (ph)
      P_FETCH:   begin b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      P_DECODE:  begin a = 2'b01; b = 2'b01; end
      P_MEMADR:  begin a = 2'b10; b = 2'b01; end
      P_MEMREAD: adr = 1;
      P_MEMWB:   begin res = 2'b01; regw = 1; end
      P_MEMWR:   begin adr = 1; memw = 1; end
      P_EXECR:   begin a = 2'b10; alu = alu_of(o, f3, f7); end
      P_EXECI:   begin a = 2'b10; b = 2'b01; alu = alu_of(o, f3, f7); end
      P_ALUWB:   regw = 1;
      P_BEQ:     begin a = 2'b10; alu = 3'b001; pcw = z; end
      P_JAL:     begin a = 2'b01; b = 2'b10; pcw = 1; end
      default:   ill = 1;
    endcase
    return {pcw, adr, memw, irw, regw, res, a, b, alu, imm_of(o), ill};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb,
            alucontrol, immsrc, illegal};
  endfunction

  function automatic void build_seq(input logic [6:0] o, input logic [2:0] f3);
    seq.delete();
    seq.push_back(P_FETCH);
    seq.push_back(P_DECODE);
    case (o)
      LW: begin seq.push_back(P_MEMADR); seq.push_back(P_MEMREAD); seq.push_back(P_MEMWB); end
      SW: begin seq.push_back(P_MEMADR); seq.push_back(P_MEMWR); end
      RT: if (f3_legal(f3)) begin seq.push_back(P_EXECR); seq.push_back(P_ALUWB); end
          else seq.push_back(P_TRAP);
      IT: if (f3_legal(f3)) begin seq.push_back(P_EXECI); seq.push_back(P_ALUWB); end
          else seq.push_back(P_TRAP);
      BQ: if (f3 == 3'b000) seq.push_back(P_BEQ);
          else seq.push_back(P_TRAP);
      JL: begin seq.push_back(P_JAL); seq.push_back(P_ALUWB); end
      default: seq.push_back(P_TRAP);
    endcase
  endfunction

  // Runs one instruction from FETCH, checking every cycle against the phase list.
  // zmode: 0/1 fixes ZERO, 2 randomizes it.
  task automatic applyStimulus(input logic [6:0] iop, input logic [2:0] if3, input logic if7,
                               input bit rand_ready, input int zmode, output int ncyc);
    int  idx;
    bit  adv, ret;
    idx = 0;
    ncyc = 0;
    build_seq(iop, if3);
    op = iop; funct3 = if3; funct7b5 = if7;
    while (idx < seq.size() && ncyc < 100) begin
      mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge clk);
      checkOutput($sformatf("outputs phase %0d", seq[idx]), 32'(dut_vec()),
                  32'(model_outputs(seq[idx], mem_ready, zero, iop, if3, if7)));
      checkOutput("instret", instret, exp_instret);
      adv = !((seq[idx] == P_FETCH || seq[idx] == P_MEMREAD || seq[idx] == P_MEMWR) && !mem_ready);
      ret = adv && (seq[idx] inside {P_MEMWB, P_ALUWB, P_BEQ, P_MEMWR});
      tick();
      if (adv) idx++;
      if (ret) exp_instret = exp_instret + 32'd1;
      ncyc++;
    end
    if (ncyc >= 100) checkOutput("instr_timeout", 32'(ncyc), 32'(seq.size()));
  endtask

  task automatic trap_hold(input int n);
    for (int k = 0; k < n; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("trap_outputs", 32'(dut_vec()),
                  32'(model_outputs(P_TRAP, mem_ready, zero, op, funct3, funct7b5)));
      checkOutput("trap_instret", instret, exp_instret);
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b0;
    #1;
    checkOutput("rst_enables", {28'd0, memwrite, regwrite, irwrite, pcwrite}, 32'd0);
    @(negedge clk);
    checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
    checkOutput("rst_instret", instret, 32'd0);
    exp_instret = 32'd0;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n, base, wcnt;
    logic [6:0] rop;
    logic [2:0] rf3;

    vecs[0]  = '{RT, 3'b000, 1'b1, 2'b00, 3'b001, 1'b0};
    vecs[1]  = '{IT, 3'b000, 1'b1, 2'b00, 3'b000, 1'b0};
    vecs[2]  = '{RT, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0};
    vecs[3]  = '{RT, 3'b010, 1'b0, 2'b00, 3'b101, 1'b0};
    vecs[4]  = '{RT, 3'b110, 1'b1, 2'b00, 3'b011, 1'b0};
    vecs[5]  = '{IT, 3'b111, 1'b0, 2'b00, 3'b010, 1'b0};
    vecs[6]  = '{RT, 3'b001, 1'b0, 2'b00, 3'b000, 1'b1};
    vecs[7]  = '{IT, 3'b101, 1'b1, 2'b00, 3'b000, 1'b1};
    vecs[8]  = '{BQ, 3'b000, 1'b0, 2'b10, 3'b001, 1'b0};
    vecs[9]  = '{BQ, 3'b001, 1'b0, 2'b10, 3'b000, 1'b1};
    vecs[10] = '{SW, 3'b010, 1'b0, 2'b01, 3'b000, 1'b0};
    vecs[11] = '{LW, 3'b010, 1'b0, 2'b00, 3'b000, 1'b0};
    vecs[12] = '{JL, 3'b000, 1'b0, 2'b11, 3'b000, 1'b0};
    vecs[13] = '{7'b1111111, 3'b000, 1'b0, 2'b00, 3'b000, 1'b1};
    vecs[14] = '{7'b0110111, 3'b000, 1'b0, 2'b00, 3'b000, 1'b1};

    op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    exp_instret = 32'd0;
    do_reset();

    // Decode table: immediate format in DECODE, then ALU op / trap one cycle later.
    for (int i = 0; i < 15; i++) begin
      do_reset();
      op = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7;
      mem_ready = 1'b1;
      tick();
      @(negedge clk);
      checkOutput($sformatf("vec%0d_immsrc", i), {30'd0, immsrc}, {30'd0, vecs[i].imm});
      tick();
      @(negedge clk);
      checkOutput($sformatf("vec%0d_alucontrol", i), {29'd0, alucontrol}, {29'd0, vecs[i].alu});
      checkOutput($sformatf("vec%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].trap});
    end

    // lw with memory always ready: five cycles, one retirement.
    do_reset();
    applyStimulus(LW, 3'b010, 1'b0, 0, 0, n);
    checkOutput("lw_cycles", 32'(n), 32'd5);
    checkOutput("lw_instret", instret, 32'd1);

    // beq taken then not taken.
    applyStimulus(BQ, 3'b000, 1'b0, 0, 1, n);
    applyStimulus(BQ, 3'b000, 1'b0, 0, 0, n);
    checkOutput("beq_instret", instret, 32'd3);

    // sw stalled three cycles in MEMWR.
    op = SW; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
    tick(); tick(); tick();
    base = int'(exp_instret);
    wcnt = 0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      @(negedge clk);
      if (memwrite) wcnt++;
      if (k == 0) checkOutput("sw_immsrc", {30'd0, immsrc}, 32'd1);
      tick();
      checkOutput($sformatf("sw_instret_%0d", k), instret, 32'(base + ((k == 3) ? 1 : 0)));
    end
    checkOutput("sw_memwrite_cycles", 32'(wcnt), 32'd4);
    exp_instret = exp_instret + 32'd1;

    // Reset in the middle of a stalled store.
    op = SW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("midwr_memwrite_before", {31'd0, memwrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midwr_memwrite_reset", {31'd0, memwrite}, 32'd0);
    checkOutput("midwr_instret_reset", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 32'd0;
    tick();
    @(negedge clk);
    checkOutput("midwr_fetch_after", {26'd0, resultsrc, alusrcb, adrsrc, memwrite}, {26'd0, 2'b10, 2'b10, 1'b0, 1'b0});
    checkOutput("midwr_instret_after", instret, 32'd0);
    tick();

    // Illegal opcode: sticky trap for 20 cycles with a frozen counter.
    applyStimulus(7'b1111111, 3'b000, 1'b0, 0, 2, n);
    trap_hold(20);

    // Counter wrap on retiring a jal from an all-ones count.
    do_reset();
    force dut.instret = 32'hFFFF_FFFF;
    tick();
    release dut.instret;
    exp_instret = 32'hFFFF_FFFF;
    applyStimulus(JL, 3'b000, 1'b0, 0, 0, n);
    checkOutput("jal_wrap", instret, 32'd0);

    // Randomized instruction stream.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      int k;
      k = $urandom_range(0, 19);
      case (k % 6)
        0: rop = LW; 1: rop = SW; 2: rop = RT; 3: rop = IT; 4: rop = BQ; default: rop = JL;
      endcase
      if (k >= 18) rop = (k == 18) ? 7'b1111111 : 7'b0110111;
      rf3 = 3'($urandom_range(0, 7));
      if ((rop == RT || rop == IT) && $urandom_range(0, 7) != 0) begin
        case ($urandom_range(0, 3))
          0: rf3 = 3'b000; 1: rf3 = 3'b010; 2: rf3 = 3'b110; default: rf3 = 3'b111;
        endcase
      end
      if (rop == BQ && $urandom_range(0, 7) != 0) rf3 = 3'b000;
      applyStimulus(rop, rf3, 1'($urandom_range(0, 1)), 1, 2, n);
      if (seq[seq.size() - 1] == P_TRAP) begin
        trap_hold(3);
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: MC_CONTROLLER

Interface
REQ-001 No parameters; all encodings come from the shared package.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 OP  in  7  instruction opcode, INSTR[6:0] from the instruction register.
REQ-006 FUNCT3  in  3  INSTR[14:12].
REQ-007 FUNCT7B5  in  1  INSTR[30].
REQ-008 ZERO  in  1  ALU zero flag.
REQ-009 MEM_READY  in  1  memory completes the current access this cycle.
REQ-010 Outputs, all 1 bit unless stated:
- PCWRITE: PC load.
- ADRSRC: memory address select.
- MEMWRITE: memory write enable.
- IRWRITE: instruction register load.
- REGWRITE: register file write enable.
- RESULTSRC [1:0]: result mux select.
- ALUSRCA [1:0]: ALU A select.
- ALUSRCB [1:0]: ALU B select.
- ALUCONTROL [2:0]: ALU operation.
- IMMSRC [1:0]: EXTEND select; 00 I, 01 S, 10 B, 11 J.
- ILLEGAL: sticky illegal-instruction flag.
- INSTRET [31:0]: retired-instruction count.

Function
REQ-011 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP; one state per cycle unless stalled.
REQ-012 FETCH: ADRSRC=0, ALUSRCA=00, ALUSRCB=10, RESULTSRC=10, ALUOP=00.
- FETCH holds while MEM_READY=0, with IRWRITE=0 and PCWRITE=0.
- In the cycle MEM_READY=1, FETCH asserts IRWRITE=1 and PCWRITE=1, then goes to DECODE.
REQ-013 DECODE: ALUSRCA=01, ALUSRCB=01, ALUOP=00. Next state by OP:
- lw 0000011 and sw 0100011 -> MEMADR.
- R-type 0110011 -> EXECR.
- I-type 0010011 -> EXECI.
- beq 1100011 -> BEQ.
- jal 1101111 -> JAL.
- Any other OP -> TRAP.
REQ-014 DECODE also goes to TRAP when:
- OP is beq and FUNCT3!=000;
- OP is R-type or I-type and FUNCT3 is not in {000,010,110,111}.
REQ-015 MEMADR: ALUSRCA=10, ALUSRCB=01, ALUOP=00. Goes to MEMREAD for lw, MEMWR for sw.
REQ-016 MEMREAD: ADRSRC=1, RESULTSRC=00. Holds until MEM_READY=1, then goes to MEMWB.
REQ-017 MEMWB: RESULTSRC=01, REGWRITE=1, then FETCH.
REQ-018 MEMWR: ADRSRC=1, RESULTSRC=00, MEMWRITE=1 held until MEM_READY=1, then FETCH.
REQ-019 EXECR: ALUSRCA=10, ALUSRCB=00, ALUOP=10. EXECI: ALUSRCA=10, ALUSRCB=01, ALUOP=10. Both go to ALUWB.
REQ-020 ALUWB: RESULTSRC=00, REGWRITE=1, then FETCH.
REQ-021 BEQ: ALUSRCA=10, ALUSRCB=00, ALUOP=01, RESULTSRC=00. PCWRITE=ZERO (same cycle, combinational). Then FETCH.
REQ-022 JAL: ALUSRCA=01, ALUSRCB=10, ALUOP=00, RESULTSRC=00, PCWRITE=1, then ALUWB.
REQ-023 TRAP: ILLEGAL=1 and all enables 0; TRAP is left only by reset.
REQ-024 IMMSRC is decoded combinationally from OP in every state: lw/I-type 00, sw 01, beq 10, jal 11, others 00.
REQ-025 ALUCONTROL mapping:
- ALUOP 00 -> 000 add.
- ALUOP 01 -> 001 sub.
- ALUOP 10 by FUNCT3: 000 -> sub(001) if {OP[5],FUNCT7B5}=11, else add(000); 010 -> 101 slt; 110 -> 011 or; 111 -> 010 and.
REQ-026 Enables not listed for a state are 0. Mux selects not listed for a state are 00/0.
REQ-027 INSTRET increments by 1 on the clock edge leaving MEMWB, ALUWB, BEQ, or MEMWR with MEM_READY=1. It wraps from FFFF_FFFF to 0.
REQ-028 All outputs except ILLEGAL and INSTRET are Moore/combinational from the state and the inputs. State, ILLEGAL and INSTRET are registered.

Reset
REQ-029 RST_N=0 immediately forces:
- state FETCH;
- ILLEGAL=0;
- INSTRET=0;
- MEMWRITE, REGWRITE, IRWRITE and PCWRITE to 0 regardless of MEM_READY.
REQ-030 Reset asserted mid-stall aborts the access; the first active edge after release evaluates FETCH.

Structure
REQ-031 Package RV32I_PKG holds:
- the state enum;
- opcode constants;
- IMMSRC encodings ITY/STY/BTY/JTY;
- ALUOP and ALUCONTROL encodings.
REQ-032 One sub-module ALUDEC (OP[5], FUNCT3, FUNCT7B5, ALUOP -> ALUCONTROL); the FSM and INSTRET stay in MC_CONTROLLER.

Verification
REQ-033 Reset mid-MEMWR with MEM_READY=0 -> MEMWRITE drops immediately; after release, FETCH; INSTRET=0.
REQ-034 lw (OP=0000011), MEM_READY=1 always -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles; IMMSRC=00; REGWRITE only in the 5th cycle; INSTRET +1.
REQ-035 sw with MEM_READY low for 3 cycles in MEMWR -> MEMWRITE=1 for 4 cycles; IMMSRC=01; INSTRET +1 only on the final edge.
REQ-036 beq with ZERO=1, then with ZERO=0 -> PCWRITE=1 and PCWRITE=0 in BEQ respectively; IMMSRC=10; ALUCONTROL=001.
REQ-037 R-type sub (FUNCT3=000, FUNCT7B5=1) -> ALUCONTROL=001 in EXECR. Same fields with OP=0010011 -> ALUCONTROL=000 (addi).
REQ-038 OP=1111111 in DECODE -> TRAP; ILLEGAL=1 held for 20 cycles; INSTRET frozen. Also preload INSTRET=FFFF_FFFF (force), retire jal -> INSTRET=0.
